// File: rtl/load_store_multiple_issue_stage.sv
// Expands one single/multiple load-store descriptor into per-register
// memory-stage control words, one beat per accepted handshake.
// Ports: clk_in, reset_in (async, active-low), flush_in,
//   start_in/start_ready_out plus the descriptor (instr_tag_in, rn_addr_in,
//   rn_data_in, reg_list_in, load_in, up_in, pre_in, instr_confirmed_in),
//   reg_rd_addr_out/reg_rd_data_in for the register-file read,
//   mem_stage_ready_in, control_word_out, busy_out, done_out.
module load_store_multiple_issue_stage #(
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 4
) (
  input  logic                clk_in,
  input  logic                reset_in,
  input  logic                flush_in,
  input  logic                start_in,
  output logic                start_ready_out,
  input  logic [TAG_W-1:0]    instr_tag_in,
  input  logic [RADDR_W-1:0]  rn_addr_in,
  input  logic [DATA_W-1:0]   rn_data_in,
  input  logic [15:0]         reg_list_in,
  input  logic                load_in,
  input  logic                up_in,
  input  logic                pre_in,
  input  logic                instr_confirmed_in,
  output logic [RADDR_W-1:0]  reg_rd_addr_out,
  input  logic [DATA_W-1:0]   reg_rd_data_in,
  input  logic                mem_stage_ready_in,
  output logic [TAG_W+2*RADDR_W+3*DATA_W+12:0] control_word_out,
  output logic                busy_out,
  output logic                done_out
);

  localparam int CW_W = TAG_W + 2*RADDR_W + 3*DATA_W + 13;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    ISSUE
  } state_e;

  state_e              state_q;
  logic [TAG_W-1:0]    tag_q;
  logic [RADDR_W-1:0]  rn_addr_q;
  logic [DATA_W-1:0]   rn_q;
  logic [15:0]         rem_q;
  logic                load_q;
  logic                up_q;
  logic                pre_q;
  logic                conf_q;
  logic [DATA_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wb_q;
  logic [CW_W-1:0]     cw_q;
  logic                done_q;

  logic [4:0]          cnt;
  logic [DATA_W-1:0]   off;
  logic [DATA_W-1:0]   start_addr;
  logic [DATA_W-1:0]   wb_calc;
  logic [DATA_W-1:0]   beat_addr;
  logic [DATA_W-1:0]   beat_wb;
  logic [15:0]         onehot;
  logic [RADDR_W-1:0]  idx;
  logic                last;
  logic [CW_W-1:0]     beat;
  logic                can_load;
  logic                accept;

  always_comb begin
    cnt = '0;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'b0, rem_q[i]};
    end
    for (int i = 15; i >= 0; i--) begin
      if (rem_q[i]) idx = RADDR_W'(i);
    end
    // isolate lowest set bit of the remaining list
    onehot = rem_q & (~rem_q + 16'd1);
    last   = ((rem_q & ~onehot) == 16'd0);
    off    = DATA_W'({cnt, 2'b00});
    unique case ({up_q, pre_q})
      2'b10:   start_addr = rn_q;
      2'b11:   start_addr = rn_q + DATA_W'(4);
      2'b00:   start_addr = rn_q - off + DATA_W'(4);
      default: start_addr = rn_q - off;
    endcase
    wb_calc   = up_q ? (rn_q + off) : (rn_q - off);
    beat_addr = (state_q == CALC) ? start_addr : addr_q;
    beat_wb   = (state_q == CALC) ? wb_calc : wb_q;
    beat = {tag_q, idx, rn_addr_q, reg_rd_data_in,
            beat_wb, beat_addr, 1'b0, 3'd1, 2'd1,
            load_q ? 4'h0 : 4'hF, conf_q, ~last, 1'b1};
    can_load = ~cw_q[0] | mem_stage_ready_in;
    accept   = cw_q[0] & mem_stage_ready_in;
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q   <= IDLE;
      tag_q     <= '0;
      rn_addr_q <= '0;
      rn_q      <= '0;
      rem_q     <= '0;
      load_q    <= 1'b0;
      up_q      <= 1'b0;
      pre_q     <= 1'b0;
      conf_q    <= 1'b0;
      addr_q    <= '0;
      wb_q      <= '0;
      cw_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush_in) begin
        state_q <= IDLE;
        cw_q    <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start_in) begin
              tag_q     <= instr_tag_in;
              rn_addr_q <= rn_addr_in;
              rn_q      <= rn_data_in;
              rem_q     <= reg_list_in;
              load_q    <= load_in;
              up_q      <= up_in;
              pre_q     <= pre_in;
              conf_q    <= instr_confirmed_in;
              state_q   <= CALC;
            end
          end
          CALC: begin
            wb_q <= wb_calc;
            if (cnt == 5'd0) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              cw_q    <= beat;
              rem_q   <= rem_q & ~onehot;
              addr_q  <= start_addr + DATA_W'(4);
              state_q <= ISSUE;
            end
          end
          ISSUE: begin
            if (can_load && (rem_q != 16'd0)) begin
              cw_q   <= beat;
              rem_q  <= rem_q & ~onehot;
              addr_q <= addr_q + DATA_W'(4);
            end else if (accept) begin
              cw_q[0] <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign start_ready_out  = (state_q == IDLE);
  assign busy_out         = (state_q != IDLE);
  assign done_out         = done_q;
  assign control_word_out = cw_q;
  assign reg_rd_addr_out  = idx;

endmodule

// File: tb/tb_load_store_multiple_issue_stage.sv
// Scoreboard bench for load_store_multiple_issue_stage.
// Directed descriptors; a negedge monitor checks every accepted beat.
module tb_load_store_multiple_issue_stage;

  typedef logic [120:0] cw_t;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        flush_in;
  logic        start_in;
  logic        start_ready_out;
  logic [3:0]  instr_tag_in;
  logic [3:0]  rn_addr_in;
  logic [31:0] rn_data_in;
  logic [15:0] reg_list_in;
  logic        load_in;
  logic        up_in;
  logic        pre_in;
  logic        instr_confirmed_in;
  logic [3:0]  reg_rd_addr_out;
  logic [31:0] reg_rd_data_in;
  logic        mem_stage_ready_in;
  cw_t         control_word_out;
  logic        busy_out;
  logic        done_out;

  logic [31:0] regs [16];
  cw_t         exp_q [$];
  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  cw_t         prev_cw = '0;
  bit          prev_hold = 0;
  bit          prev_flush = 0;

  always #5 clk_in = ~clk_in;

  assign reg_rd_data_in = regs[reg_rd_addr_out];

  load_store_multiple_issue_stage dut (
    .clk_in             (clk_in),
    .reset_in           (reset_in),
    .flush_in           (flush_in),
    .start_in           (start_in),
    .start_ready_out    (start_ready_out),
    .instr_tag_in       (instr_tag_in),
    .rn_addr_in         (rn_addr_in),
    .rn_data_in         (rn_data_in),
    .reg_list_in        (reg_list_in),
    .load_in            (load_in),
    .up_in              (up_in),
    .pre_in             (pre_in),
    .instr_confirmed_in (instr_confirmed_in),
    .reg_rd_addr_out    (reg_rd_addr_out),
    .reg_rd_data_in     (reg_rd_data_in),
    .mem_stage_ready_in (mem_stage_ready_in),
    .control_word_out   (control_word_out),
    .busy_out           (busy_out),
    .done_out           (done_out)
  );

  function automatic cw_t mk(input logic [3:0] tag, input logic [3:0] rd,
                             input logic [31:0] sd, input logic [31:0] wb,
                             input logic [31:0] addr, input logic ld,
                             input logic cf, input logic lsm);
    return {tag, rd, 4'd13, sd, wb, addr, 1'b0, 3'd1, 2'd1,
            ld ? 4'h0 : 4'hF, cf, lsm, 1'b1};
  endfunction

  task automatic chk(input string nm, input cw_t act, input cw_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (reset_in && done_out) done_cnt++;
    if (reset_in && prev_hold && !prev_flush)
      chk("hold_stable", control_word_out, prev_cw);
    if (reset_in && control_word_out[0] && mem_stage_ready_in) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_beat got=%h want=none", control_word_out);
      end else begin
        chk("beat", control_word_out, exp_q.pop_front());
      end
    end
    prev_hold  = reset_in && control_word_out[0] && !mem_stage_ready_in;
    prev_cw    = control_word_out;
    prev_flush = flush_in;
  end

  task automatic issue(input logic [3:0] tag, input logic [31:0] rn,
                       input logic [15:0] list, input logic ld,
                       input logic up, input logic pre, input logic cf);
    int n = 0;
    while (!start_ready_out && n < 40) begin
      @(posedge clk_in); #1;
      n++;
    end
    chk("issue_ready", cw_t'(start_ready_out), cw_t'(1));
    instr_tag_in       = tag;
    rn_addr_in         = 4'd13;
    rn_data_in         = rn;
    reg_list_in        = list;
    load_in            = ld;
    up_in              = up;
    pre_in             = pre;
    instr_confirmed_in = cf;
    start_in           = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
  endtask

  task automatic wait_done(input int target, input string nm);
    for (int i = 0; i < 60 && done_cnt < target; i++) begin
      @(posedge clk_in); #1;
    end
    chk(nm, cw_t'(done_cnt), cw_t'(target));
    chk({nm, "_drained"}, cw_t'(exp_q.size()), cw_t'(0));
  endtask

  task automatic wait_rd(input logic [3:0] rd);
    for (int i = 0; i < 40; i++) begin
      if (control_word_out[0] && control_word_out[116:113] == rd) break;
      @(posedge clk_in); #1;
    end
    chk("reach_beat", cw_t'(control_word_out[116:113]), cw_t'(rd));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 32'h11 * i;
    reset_in = 1'b0;
    flush_in = 1'b0;
    start_in = 1'b0;
    instr_tag_in = '0;
    rn_addr_in = '0;
    rn_data_in = '0;
    reg_list_in = '0;
    load_in = 1'b0;
    up_in = 1'b0;
    pre_in = 1'b0;
    instr_confirmed_in = 1'b0;
    mem_stage_ready_in = 1'b1;
    #12;
    chk("rst_cw", control_word_out, '0);
    chk("rst_busy", cw_t'(busy_out), cw_t'(0));
    chk("rst_done", cw_t'(done_out), cw_t'(0));
    chk("rst_ready", cw_t'(start_ready_out), cw_t'(1));
    @(posedge clk_in); #1;
    reset_in = 1'b1;

    // STM IA with latency check; a second start during CALC is ignored
    exp_q.push_back(mk(1, 1, 32'h11, 32'h1008, 32'h1000, 0, 1, 1));
    exp_q.push_back(mk(1, 3, 32'h33, 32'h1008, 32'h1004, 0, 1, 0));
    instr_tag_in = 4'd1; rn_addr_in = 4'd13; rn_data_in = 32'h1000;
    reg_list_in = 16'h000A; load_in = 0; up_in = 1; pre_in = 0;
    instr_confirmed_in = 1; start_in = 1;
    @(posedge clk_in); #1;
    reg_list_in = 16'hFFFF;
    chk("calc_ready", cw_t'(start_ready_out), cw_t'(0));
    chk("calc_no_beat", cw_t'(control_word_out[0]), cw_t'(0));
    @(posedge clk_in); #1;
    start_in = 0;
    chk("first_beat_lat", cw_t'(control_word_out[0]), cw_t'(1));
    wait_done(1, "stm_ia_done");

    // LDM DB, unconfirmed
    exp_q.push_back(mk(2, 0, 32'h0, 32'h1FF8, 32'h1FF8, 1, 0, 1));
    exp_q.push_back(mk(2, 15, 32'hFF, 32'h1FF8, 32'h1FFC, 1, 0, 0));
    issue(2, 32'h2000, 16'h8001, 1, 0, 1, 0);
    wait_done(2, "ldm_db_done");

    // STM IB with backpressure on beat 2
    exp_q.push_back(mk(3, 0, 32'h0, 32'hC, 32'h4, 0, 1, 1));
    exp_q.push_back(mk(3, 1, 32'h11, 32'hC, 32'h8, 0, 1, 1));
    exp_q.push_back(mk(3, 2, 32'h22, 32'hC, 32'hC, 0, 1, 0));
    issue(3, 32'h0, 16'h0007, 0, 1, 1, 1);
    wait_rd(4'd1);
    mem_stage_ready_in = 0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("bp_addr", cw_t'(control_word_out[44:13]), cw_t'(32'h8));
    mem_stage_ready_in = 1;
    wait_done(3, "stm_ib_done");

    // empty list; start while busy ignored
    instr_tag_in = 4'd9; rn_data_in = 32'h500; reg_list_in = 16'h0;
    load_in = 1; up_in = 1; pre_in = 0; start_in = 1;
    @(posedge clk_in); #1;
    reg_list_in = 16'h0003;
    chk("empty_busy", cw_t'(busy_out), cw_t'(1));
    @(posedge clk_in); #1;
    start_in = 0;
    chk("empty_done", cw_t'(done_out), cw_t'(1));
    chk("empty_no_beat", cw_t'(control_word_out[0]), cw_t'(0));
    chk("empty_idle", cw_t'(start_ready_out), cw_t'(1));
    wait_done(4, "empty_cnt");

    // LDM IA address wrap
    exp_q.push_back(mk(4, 0, 32'h0, 32'h4, 32'hFFFFFFFC, 1, 1, 1));
    exp_q.push_back(mk(4, 1, 32'h11, 32'h4, 32'h0, 1, 1, 0));
    issue(4, 32'hFFFFFFFC, 16'h0003, 1, 1, 0, 1);
    wait_done(5, "wrap_done");

    // flush during beat 2 of 4
    exp_q.push_back(mk(5, 0, 32'h0, 32'h110, 32'h100, 0, 1, 1));
    issue(5, 32'h100, 16'h000F, 0, 1, 0, 1);
    wait_rd(4'd1);
    mem_stage_ready_in = 0;
    flush_in = 1;
    @(posedge clk_in); #1;
    flush_in = 0;
    chk("flush_start", cw_t'(control_word_out[0]), cw_t'(0));
    chk("flush_ready", cw_t'(start_ready_out), cw_t'(1));
    chk("flush_done", cw_t'(done_out), cw_t'(0));
    mem_stage_ready_in = 1;
    repeat (4) @(posedge clk_in);
    #1;
    wait_done(5, "flush_cnt");

    // reset mid-beat
    exp_q.push_back(mk(6, 0, 32'h0, 32'h110, 32'h100, 0, 1, 1));
    issue(6, 32'h100, 16'h000F, 0, 1, 0, 1);
    wait_rd(4'd1);
    mem_stage_ready_in = 0;
    #2;
    reset_in = 0;
    #1;
    chk("arst_cw", control_word_out, '0);
    chk("arst_busy", cw_t'(busy_out), cw_t'(0));
    chk("arst_ready", cw_t'(start_ready_out), cw_t'(1));
    @(posedge clk_in); #3;
    reset_in = 1;
    mem_stage_ready_in = 1;
    @(posedge clk_in); #1;
    wait_done(5, "arst_cnt");

    // LDM DA after reset
    exp_q.push_back(mk(7, 4, 32'h44, 32'h2FF8, 32'h2FFC, 1, 1, 1));
    exp_q.push_back(mk(7, 5, 32'h55, 32'h2FF8, 32'h3000, 1, 1, 0));
    issue(7, 32'h3000, 16'h0030, 1, 0, 0, 1);
    wait_done(6, "ldm_da_done");

    repeat (3) @(posedge clk_in);
    #1;
    chk("final_idle", cw_t'(start_ready_out), cw_t'(1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
